morse_symbol_timer: RTL and testbench

- Sits directly downstream of the button debouncer and upstream of the character decoder.
- Measures the length of each debounced press and each idle gap in clock ticks.
- Classifies each press as dot, dash or illegal, and each gap as a character end or a word end.
- Emits one single-cycle event per classification to the character decoder.

---
 rtl/morse_symbol_timer.sv | 135 +++++++++++++
 tb/tb_morse_symbol_timer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/morse_symbol_timer.sv
`default_nettype none
// ============================================================================
// Module   : morse_symbol_timer
// Brief    : Times debounced presses and idle gaps and emits dot / dash /
//            illegal / char_end / word_end events to the character decoder.
// Revision : 1.0 - initial release
// ============================================================================
module morse_symbol_timer #(
    parameter int DASH_TICK_COUNT           = 30_000_000,
    parameter int ILLEGAL_SYMBOL_TICK_COUNT = 100_000_000,
    parameter int INTER_IDLE_TICK_COUNT     = 175_000_000,
    parameter int WORD_IDLE_TICK_COUNT      = 250_000_000,
    parameter int CNT_W                     = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_db,
    output logic       sym_valid,
    output logic [2:0] sym_type,
    output logic       press_active
);

    localparam logic [2:0] c_sym_dot      = 3'd0;
    localparam logic [2:0] c_sym_dash     = 3'd1;
    localparam logic [2:0] c_sym_illegal  = 3'd2;
    localparam logic [2:0] c_sym_char_end = 3'd3;
    localparam logic [2:0] c_sym_word_end = 3'd4;

    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_dash    = CNT_W'(DASH_TICK_COUNT);
    localparam logic [CNT_W-1:0] c_illegal = CNT_W'(ILLEGAL_SYMBOL_TICK_COUNT);
    localparam logic [CNT_W-1:0] c_inter   = CNT_W'(INTER_IDLE_TICK_COUNT);
    localparam logic [CNT_W-1:0] c_word    = CNT_W'(WORD_IDLE_TICK_COUNT);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_sym_valid;
    logic [2:0]       r_sym_type;
    logic             r_press_active;
    logic             w_evt;
    logic [2:0]       w_evt_type;

    assign w_cnt_inc = r_cnt + c_one;

    // r_cnt counts samples of the current phase; the incoming sample is the
    // (r_cnt+1)-th, so gap thresholds are decided on w_cnt_inc.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_evt       = 1'b0;
        w_evt_type  = r_sym_type;
        case (r_state)
            ST_START: begin
                if (btn_db) begin
                    w_state_nxt = ST_PRESS;
                    w_cnt_nxt   = c_one;
                end
            end
            ST_PRESS: begin
                if (btn_db) begin
                    if (r_cnt < c_illegal) begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_evt = 1'b1;
                    if (r_cnt >= c_illegal) begin
                        w_evt_type = c_sym_illegal;
                    end else if (r_cnt >= c_dash) begin
                        w_evt_type = c_sym_dash;
                    end else begin
                        w_evt_type = c_sym_dot;
                    end
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = c_one;
                end
            end
            ST_GAP: begin
                if (btn_db) begin
                    w_state_nxt = ST_PRESS;
                    w_cnt_nxt   = c_one;
                end else if (w_cnt_inc == c_word) begin
                    w_evt       = 1'b1;
                    w_evt_type  = c_sym_word_end;
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end else begin
                    if (r_cnt < c_word) begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                    if (w_cnt_inc == c_inter) begin
                        w_evt      = 1'b1;
                        w_evt_type = c_sym_char_end;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_START;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_START;
            r_cnt          <= '0;
            r_sym_valid    <= 1'b0;
            r_sym_type     <= c_sym_dot;
            r_press_active <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_sym_valid    <= w_evt;
            r_press_active <= (r_state == ST_PRESS);
            if (w_evt) begin
                r_sym_type <= w_evt_type;
            end
        end
    end

    assign sym_valid    = r_sym_valid;
    assign sym_type     = r_sym_type;
    assign press_active = r_press_active;

endmodule
`default_nettype wire

// File: tb/tb_morse_symbol_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_symbol_timer
// Brief    : Scoreboard bench for morse_symbol_timer with scaled thresholds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_symbol_timer;

    localparam int c_dash    = 30;
    localparam int c_illegal = 100;
    localparam int c_inter   = 175;
    localparam int c_word    = 250;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_db = 1'b0;
    logic       sym_valid;
    logic [2:0] sym_type;
    logic       press_active;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int typ;
        int cyc;
    } evt_t;

    evt_t sb[$];

    morse_symbol_timer #(
        .DASH_TICK_COUNT          (c_dash),
        .ILLEGAL_SYMBOL_TICK_COUNT(c_illegal),
        .INTER_IDLE_TICK_COUNT    (c_inter),
        .WORD_IDLE_TICK_COUNT     (c_word),
        .CNT_W                    (9)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .btn_db      (btn_db),
        .sym_valid   (sym_valid),
        .sym_type    (sym_type),
        .press_active(press_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Compare every strobe against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && sym_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_evt", 32'(sym_type), -1);
            end else begin
                evt_t e;
                e = sb.pop_front();
                check("evt_type", 32'(sym_type), e.typ);
                check("evt_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input logic val, input int n);
        btn_db = val;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press for n samples then stay idle m samples; the expected events and
    // the clock edge that decides each one are derived from n and m alone.
    task automatic press_idle(input int n, input int m);
        evt_t e;
        int   r;
        drive(1'b1, n);
        if (n >= 2) check("press_active_hi", 32'(press_active), 1);
        r     = cyc + 1;
        e.typ = (n >= c_illegal) ? 2 : (n >= c_dash) ? 1 : 0;
        e.cyc = r;
        sb.push_back(e);
        if (m >= c_inter) begin
            e.typ = 3;
            e.cyc = r + c_inter - 1;
            sb.push_back(e);
        end
        if (m >= c_word) begin
            e.typ = 4;
            e.cyc = r + c_word - 1;
            sb.push_back(e);
        end
        drive(1'b0, m);
    endtask

    initial begin
        rst    = 1'b1;
        btn_db = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(sym_valid), 0);
        check("rst_type", 32'(sym_type), 0);
        check("rst_press_active", 32'(press_active), 0);
        rst = 1'b0;

        drive(1'b0, 500);
        check("quiet_press_active", 32'(press_active), 0);
        check("quiet_no_pending", sb.size(), 0);

        press_idle(29, 300);
        press_idle(30, 300);
        press_idle(99, 300);
        press_idle(100, 300);
        press_idle(400, 300);

        press_idle(5, 174);
        press_idle(40, 300);

        press_idle(10, 200);
        press_idle(50, 300);

        // Reset in the 50th cycle of a 60-cycle press, held through release.
        drive(1'b1, 49);
        check("pre_rst_press_active", 32'(press_active), 1);
        rst = 1'b1;
        drive(1'b1, 1);
        check("rst_mid_press_active", 32'(press_active), 0);
        check("rst_mid_valid", 32'(sym_valid), 0);
        drive(1'b1, 10);
        drive(1'b0, 2);
        rst = 1'b0;
        drive(1'b0, 20);
        press_idle(10, 300);

        drive(1'b0, 20);
        check("leftover_events", sb.size(), 0);
        check("final_press_active", 32'(press_active), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
